assoc_store: RTL and testbench

Parametrised, synthesizable associative store: a fixed-capacity key/value table holding up to ENTRIES sparse keys of KEY_W bits, each with DATA_W bits of data. It supports insert/update, lookup, delete, ordered key iteration (ceiling search) and a bulk clear. Each command gets a response one cycle later, and the block reports occupancy. It replaces the simulation-only dynamic associative array, so sparse-address memory models can also be used in synthesized test harnesses and in the fabric.

---
 rtl/assoc_store.sv | 191 +++++++++++++++++++
 tb/tb_assoc_store.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/assoc_store.sv
// assoc_store: fixed-capacity key/value table with parallel match, lowest-free
// allocation and ceiling search. One command per cycle, response one cycle later.
module assoc_store #(
  parameter int unsigned KEY_W   = 64,
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned CNT_W   = $clog2(ENTRIES + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              cmd_valid,
  input  logic [1:0]        cmd_op,
  input  logic [KEY_W-1:0]  cmd_key,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic              rsp_hit,
  output logic              rsp_err,
  output logic [KEY_W-1:0]  rsp_key,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [CNT_W-1:0]  count,
  output logic              empty,
  output logic              full
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);

  localparam logic [1:0] OpRead   = 2'b00;
  localparam logic [1:0] OpWrite  = 2'b01;
  localparam logic [1:0] OpDelete = 2'b10;
  localparam logic [1:0] OpCeil   = 2'b11;

  // Table state: only the valid bits are reset, slot contents are not.
  logic [ENTRIES-1:0] r_valid;
  logic [KEY_W-1:0]   r_key  [ENTRIES];
  logic [DATA_W-1:0]  r_data [ENTRIES];
  logic [CNT_W-1:0]   r_count;

  logic               r_rsp_valid;
  logic               r_rsp_hit;
  logic               r_rsp_err;
  logic [KEY_W-1:0]   r_rsp_key;
  logic [DATA_W-1:0]  r_rsp_rdata;

  // Search results.
  logic               w_hit;
  logic [IDX_W-1:0]   w_hit_idx;
  logic               w_free;
  logic [IDX_W-1:0]   w_free_idx;
  logic               w_ceil;
  logic [KEY_W-1:0]   w_ceil_key;
  logic [DATA_W-1:0]  w_ceil_data;

  // Next-state.
  logic [ENTRIES-1:0] w_valid_d;
  logic [CNT_W-1:0]   w_count_d;
  logic               w_st_we;
  logic [IDX_W-1:0]   w_st_idx;
  logic               w_rsp_valid_d;
  logic               w_rsp_hit_d;
  logic               w_rsp_err_d;
  logic [KEY_W-1:0]   w_rsp_key_d;
  logic [DATA_W-1:0]  w_rsp_rdata_d;

  // Parallel exact match, lowest free slot and smallest valid key >= cmd_key.
  always_comb begin
    w_hit       = 1'b0;
    w_hit_idx   = '0;
    w_free      = 1'b0;
    w_free_idx  = '0;
    w_ceil      = 1'b0;
    w_ceil_key  = '0;
    w_ceil_data = '0;
    // Descending scan so the last free slot seen is the lowest index.
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (r_valid[i] && (r_key[i] == cmd_key)) begin
        w_hit     = 1'b1;
        w_hit_idx = IDX_W'(i);
      end
      if (!r_valid[i]) begin
        w_free     = 1'b1;
        w_free_idx = IDX_W'(i);
      end
    end
    for (int i = 0; i < ENTRIES; i++) begin
      if (r_valid[i] && (r_key[i] >= cmd_key) && (!w_ceil || (r_key[i] < w_ceil_key))) begin
        w_ceil      = 1'b1;
        w_ceil_key  = r_key[i];
        w_ceil_data = r_data[i];
      end
    end
  end

  // Command decode: table update and response next-state.
  always_comb begin
    w_valid_d     = r_valid;
    w_count_d     = r_count;
    w_st_we       = 1'b0;
    w_st_idx      = '0;
    w_rsp_valid_d = 1'b0;
    w_rsp_hit_d   = r_rsp_hit;
    w_rsp_err_d   = r_rsp_err;
    w_rsp_key_d   = r_rsp_key;
    w_rsp_rdata_d = r_rsp_rdata;
    if (clr) begin
      w_valid_d = '0;
      w_count_d = '0;
    end else if (cmd_valid) begin
      w_rsp_valid_d = 1'b1;
      w_rsp_hit_d   = 1'b0;
      w_rsp_err_d   = 1'b0;
      w_rsp_key_d   = cmd_key;
      w_rsp_rdata_d = '0;
      unique case (cmd_op)
        OpRead: begin
          if (w_hit) begin
            w_rsp_hit_d   = 1'b1;
            w_rsp_rdata_d = r_data[w_hit_idx];
          end
        end
        OpWrite: begin
          if (w_hit) begin
            w_rsp_hit_d   = 1'b1;
            w_rsp_rdata_d = r_data[w_hit_idx];
            w_st_we       = 1'b1;
            w_st_idx      = w_hit_idx;
          end else if (w_free) begin
            w_st_we               = 1'b1;
            w_st_idx              = w_free_idx;
            w_valid_d[w_free_idx] = 1'b1;
            w_count_d             = r_count + CNT_W'(1);
          end else begin
            w_rsp_err_d = 1'b1;
          end
        end
        OpDelete: begin
          if (w_hit) begin
            w_rsp_hit_d          = 1'b1;
            w_rsp_rdata_d        = r_data[w_hit_idx];
            w_valid_d[w_hit_idx] = 1'b0;
            w_count_d            = r_count - CNT_W'(1);
          end
        end
        OpCeil: begin
          w_rsp_hit_d   = w_ceil;
          w_rsp_key_d   = w_ceil_key;
          w_rsp_rdata_d = w_ceil_data;
        end
      endcase
    end
  end

  // Valid bits, occupancy and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid     <= '0;
      r_count     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_hit   <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_key   <= '0;
      r_rsp_rdata <= '0;
    end else begin
      r_valid     <= w_valid_d;
      r_count     <= w_count_d;
      r_rsp_valid <= w_rsp_valid_d;
      r_rsp_hit   <= w_rsp_hit_d;
      r_rsp_err   <= w_rsp_err_d;
      r_rsp_key   <= w_rsp_key_d;
      r_rsp_rdata <= w_rsp_rdata_d;
    end
  end

  // Slot key/data storage; rewriting the key on an update is harmless.
  always_ff @(posedge clk) begin
    if (w_st_we) begin
      r_key[w_st_idx]  <= cmd_key;
      r_data[w_st_idx] <= cmd_wdata;
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_hit   = r_rsp_hit;
  assign rsp_err   = r_rsp_err;
  assign rsp_key   = r_rsp_key;
  assign rsp_rdata = r_rsp_rdata;
  assign count     = r_count;
  assign empty     = (r_count == '0);
  assign full      = (r_count == CNT_W'(ENTRIES));

endmodule

// File: tb/tb_assoc_store.sv
// Bench for assoc_store: directed scenarios plus random traffic against an
// associative-array reference model.
module tb_assoc_store;

  localparam int ENTRIES = 16;
  localparam int CNT_W   = $clog2(ENTRIES + 1);

  logic             clk;
  logic             rst_n;
  logic             clr;
  logic             cmd_valid;
  logic [1:0]       cmd_op;
  logic [63:0]      cmd_key;
  logic [63:0]      cmd_wdata;
  logic             rsp_valid;
  logic             rsp_hit;
  logic             rsp_err;
  logic [63:0]      rsp_key;
  logic [63:0]      rsp_rdata;
  logic [CNT_W-1:0] count;
  logic             empty;
  logic             full;

  assoc_store #(
    .KEY_W  (64),
    .DATA_W (64),
    .ENTRIES(ENTRIES)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .cmd_valid(cmd_valid),
    .cmd_op   (cmd_op),
    .cmd_key  (cmd_key),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid),
    .rsp_hit  (rsp_hit),
    .rsp_err  (rsp_err),
    .rsp_key  (rsp_key),
    .rsp_rdata(rsp_rdata),
    .count    (count),
    .empty    (empty),
    .full     (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: key -> data.
  logic [63:0] model [bit [63:0]];
  logic [63:0] last_key;

  localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_occ();
    chk("count", 64'(count), 64'(model.num()));
    chk("empty", 64'(empty), 64'(model.num() == 0));
    chk("full", 64'(full), 64'(model.num() == ENTRIES));
  endtask

  // Issue one command, predict with the model, check the response.
  task automatic cmd(input logic [1:0] op, input logic [63:0] key, input logic [63:0] wd);
    logic        e_hit;
    logic        e_err;
    logic [63:0] e_key;
    logic [63:0] e_rdata;
    bit   [63:0] x;
    e_hit = 1'b0; e_err = 1'b0; e_key = key; e_rdata = '0;
    case (op)
      2'b00: if (model.exists(key)) begin e_hit = 1'b1; e_rdata = model[key]; end
      2'b01: begin
        if (model.exists(key)) begin
          e_hit = 1'b1; e_rdata = model[key]; model[key] = wd;
        end else if (model.num() < ENTRIES) begin
          model[key] = wd;
        end else begin
          e_err = 1'b1;
        end
      end
      2'b10: if (model.exists(key)) begin
        e_hit = 1'b1; e_rdata = model[key]; model.delete(key);
      end
      default: begin
        e_key = '0;
        if (model.first(x)) begin
          do begin
            if (x >= key) begin
              e_hit = 1'b1; e_key = x; e_rdata = model[x];
              break;
            end
          end while (model.next(x));
        end
      end
    endcase
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_key = key; cmd_wdata = wd;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    chk("rsp_valid", 64'(rsp_valid), 64'd1);
    chk("rsp_hit", 64'(rsp_hit), 64'(e_hit));
    chk("rsp_err", 64'(rsp_err), 64'(e_err));
    chk("rsp_key", rsp_key, e_key);
    chk("rsp_rdata", rsp_rdata, e_rdata);
    chk_occ();
    last_key = e_key;
  endtask

  // Idle cycle: no response strobe, response fields hold.
  task automatic idle();
    @(negedge clk);
    cmd_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("idle_rsp_key_hold", rsp_key, last_key);
  endtask

  task automatic do_clr(input bit with_cmd);
    @(negedge clk);
    clr = 1'b1;
    cmd_valid = with_cmd; cmd_op = 2'b01; cmd_key = 64'h7; cmd_wdata = 64'h77;
    @(posedge clk);
    #1;
    clr = 1'b0; cmd_valid = 1'b0;
    model.delete();
    chk("clr_rsp_valid", 64'(rsp_valid), 64'd0);
    chk_occ();
  endtask

  logic [63:0] pool [24];

  initial begin
    rst_n = 1'b0; clr = 1'b0; cmd_valid = 1'b0;
    cmd_op = '0; cmd_key = '0; cmd_wdata = '0; last_key = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_hit", 64'(rsp_hit), 64'd0);
    chk("rst_rsp_err", 64'(rsp_err), 64'd0);
    chk("rst_rsp_key", rsp_key, 64'd0);
    chk("rst_rsp_rdata", rsp_rdata, 64'd0);
    chk_occ();
    @(negedge clk);
    rst_n = 1'b1;

    // Read miss on empty table.
    cmd(2'b00, 64'h5, '0);
    idle();

    // Insert then update.
    cmd(2'b01, 64'h10, 64'hAA);
    cmd(2'b01, 64'h10, 64'hBB);
    cmd(2'b00, 64'h10, '0);

    // Fill to capacity, reject, delete, refill.
    for (int i = 0; i < ENTRIES - 1; i++) cmd(2'b01, 64'h1000 + 64'(i), {$urandom, $urandom});
    cmd(2'b01, 64'h999, 64'h1234);
    cmd(2'b00, 64'h999, '0);
    cmd(2'b10, 64'h1005, '0);
    cmd(2'b01, 64'h2000, 64'h5555);
    cmd(2'b01, 64'h2001, 64'h6666);

    // Ordered iteration.
    do_clr(1'b0);
    cmd(2'b01, 64'h3, 64'h33);
    cmd(2'b01, 64'h40, 64'h44);
    cmd(2'b01, ALL1, 64'hFF);
    cmd(2'b11, 64'h0, '0);
    cmd(2'b11, 64'h4, '0);
    cmd(2'b11, 64'h41, '0);
    cmd(2'b11, 64'h3, '0);
    cmd(2'b10, 64'h40, '0);
    cmd(2'b11, 64'h4, '0);
    cmd(2'b10, ALL1, '0);
    cmd(2'b11, 64'h4, '0);

    // clr wins over a same-cycle WRITE.
    do_clr(1'b0);
    for (int i = 0; i < 5; i++) cmd(2'b01, 64'h100 + 64'(i), 64'(i));
    do_clr(1'b1);
    cmd(2'b00, 64'h7, '0);
    cmd(2'b00, 64'h100, '0);

    // Asynchronous reset mid-stream with a command in flight.
    for (int i = 0; i < 3; i++) cmd(2'b01, 64'h50 + 64'(i), 64'hC0 + 64'(i));
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_key = 64'h53; cmd_wdata = 64'hC3;
    #2;
    rst_n = 1'b0;
    #1;
    cmd_valid = 1'b0;
    model.delete();
    last_key = '0;
    chk("arst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("arst_rsp_key", rsp_key, 64'd0);
    chk("arst_rsp_rdata", rsp_rdata, 64'd0);
    chk_occ();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) cmd(2'b00, 64'h50 + 64'(i), '0);

    // Random traffic over a small key pool so the table fills and drains.
    for (int i = 0; i < 24; i++) pool[i] = (i < 2) ? ((i == 0) ? 64'h0 : ALL1) : {$urandom, $urandom};
    for (int n = 0; n < 600; n++) begin
      logic [1:0]  op;
      logic [63:0] k;
      op = 2'($urandom_range(0, 3));
      if (op == 2'b11 && $urandom_range(0, 1) == 1) k = {$urandom, $urandom};
      else k = pool[$urandom_range(0, 23)];
      if ($urandom_range(0, 15) == 0) idle();
      else if ($urandom_range(0, 99) == 0) do_clr(1'($urandom_range(0, 1)));
      else cmd(op, k, {$urandom, $urandom});
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
